ltl_report_collector: RTL and testbench
=======================================

Name: ltl_report_collector

Overview:
Downstream consumer of an automata monitor cluster's report outputs (the per-report-STE active_state bits, e.g. four report wires per cluster). Every cycle in which `run` is high and at least one report bit is set, the block captures an entry: the symbol index plus the report vector. Entries are held in a small FIFO and drained by a valid/ready readout port toward the monitor aggregation / CSR logic. Overflow is tracked with a sticky flag and a drop counter.

Parameters:
NUM_REPORTS, 4, width of the report vector (one bit per report STE)
DEPTH, 8, FIFO entries; power of two, >= 2
IDX_W, 16, symbol-index counter width
DROP_W, 8, dropped-entry counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush/restart between traces
run  input  1  symbol-valid qualifier, the same one fed to the automata
report_in  input  NUM_REPORTS  report STE outputs, bit i = report i
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts the head entry
out_index  output  IDX_W  symbol index of the head entry
out_reports  output  NUM_REPORTS  report vector of the head entry
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky; set when an entry was dropped
drop_count  output  DROP_W  dropped entries, saturating
any_report  output  1  sticky; set when any report was captured or dropped since reset/clear

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0 during reset, FIFO is empty, sym_idx = 0.
- sym_idx counter:
  - Increments by 1 on every cycle with run=1.
  - Wraps modulo 2^IDX_W without flagging.
  - A captured entry records the sym_idx value present in the capture cycle (pre-increment). The first run cycle after reset/clear therefore has index 0.
- push_req = run & (|report_in) & ~clear. report_in is ignored when run=0.
- pop = out_valid & out_ready & ~clear.
- Push acceptance:
  - Accepted if count < DEPTH, or if count == DEPTH and pop occurs in the same cycle (simultaneous push/pop when full is legal; count unchanged).
  - Otherwise the entry is dropped: overflow <= 1, and drop_count increments, saturating at 2^DROP_W-1.
- Simultaneous push and pop when empty: the pop is impossible (out_valid=0), so only the push takes effect.
- Readout is first-word-fall-through:
  - out_valid = (count != 0).
  - out_index and out_reports show the head entry combinationally from storage.
  - An entry pushed in cycle N is visible with out_valid=1 in cycle N+1.
  - Data is stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. Pointers are log2(DEPTH) bits and wrap naturally; count is a separate register.
- any_report <= 1 on any push_req, whether accepted or dropped.
- clear: takes priority over push and pop in the same cycle. Next cycle: FIFO empty, sym_idx=0, overflow=0, drop_count=0, any_report=0. Storage contents need not be cleared.
- Reset asserted mid-drain: everything returns to reset values immediately. In-flight entries are lost and no partial handshake completes.
- out_ready asserted while out_valid=0 has no effect.
- No combinational path from out_ready to out_valid, out_index or out_reports.

Decomposition:
- Shared package ltl_monitor_pkg:
  - typedef report_entry_t, a packed struct {idx[IDX_W], reports[NUM_REPORTS]}.
  - Default constants for NUM_REPORTS, IDX_W, DEPTH.
- One sub-module: ltl_report_fifo.
  - Parameterized DEPTH and entry width; FWFT, with push/pop/full/empty/count.
  - No overflow policy inside it. The top level owns overflow detection, counters and clear priority.

Test Plan:
- Reset, then run=1 for 5 cycles, with report_in=4'b0100 only in the cycle with sym_idx=3 -> one entry {idx=3, reports=4'b0100}; out_valid rises on the next cycle; count=1.
- DEPTH=8, out_ready=0, 10 consecutive run cycles with report_in=4'b0001 -> count=8, entries idx 0..7, overflow=1, drop_count=2; draining returns idx 0..7 in order.
- FIFO full, in one cycle push_req=1 and out_ready=1 -> no drop; count stays 8; head advances; new tail idx correct.
- Report with run=0 -> nothing captured, sym_idx unchanged, any_report stays 0.
- IDX_W=4, 20 run cycles with reports at cycles 15 and 16 -> captured idx 15 then 0.
- With count=5, overflow=1 and drop_count=3, assert clear together with push and pop -> next cycle count=0, out_valid=0, overflow=0, drop_count=0; the next run cycle's capture has idx=0.

Source files
------------

// File: rtl/ltl_monitor_pkg.sv
// Shared types and default sizing for the LTL monitor report path.
package ltl_monitor_pkg;

  localparam int LTL_NUM_REPORTS = 4;
  localparam int LTL_IDX_W       = 16;
  localparam int LTL_DEPTH       = 8;
  localparam int LTL_DROP_W      = 8;

  // One captured report: the symbol index it fired on plus the report STE bits.
  typedef struct packed {
    logic [LTL_IDX_W-1:0]       idx;
    logic [LTL_NUM_REPORTS-1:0] reports;
  } report_entry_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// First-word-fall-through FIFO for report entries. It has no overflow policy:
// the caller must never push while full unless it pops in the same cycle.
module ltl_report_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int DEPTH = LTL_DEPTH,
  parameter int WIDTH = LTL_IDX_W + LTL_NUM_REPORTS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally; occupancy lives in its own register so full/empty are unambiguous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/ltl_report_collector.sv
// Captures {symbol index, report vector} whenever a monitored symbol fires any
// report, buffers the entries, and tracks drops with sticky/saturating status.
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int NUM_REPORTS = LTL_NUM_REPORTS,
  parameter int DEPTH       = LTL_DEPTH,
  parameter int IDX_W       = LTL_IDX_W,
  parameter int DROP_W      = LTL_DROP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       run,
  input  logic [NUM_REPORTS-1:0]     report_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [NUM_REPORTS-1:0]     out_reports,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       any_report
);

  localparam int ENTRY_W = IDX_W + NUM_REPORTS;

  logic [IDX_W-1:0]   sym_idx;
  logic [ENTRY_W-1:0] head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_req;
  logic               push_accept;
  logic               pop;
  logic               drop;

  // Clear masks both sides of the FIFO so a flush cycle never moves data.
  assign push_req    = run & (|report_in) & ~clear;
  assign pop         = out_valid & out_ready & ~clear;
  assign push_accept = push_req & (~fifo_full | pop);
  assign drop        = push_req & ~push_accept;

  ltl_report_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push_accept),
    .pop       (pop),
    .push_data ({sym_idx, report_in}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Head data is forced to zero while empty so nothing stale leaks out, e.g. during reset.
  assign out_valid   = ~fifo_empty;
  assign out_index   = out_valid ? head_data[ENTRY_W-1:NUM_REPORTS] : '0;
  assign out_reports = out_valid ? head_data[NUM_REPORTS-1:0] : '0;

  // Symbol index counts every run cycle and simply wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sym_idx <= '0;
    else if (clear) sym_idx <= '0;
    else if (run)   sym_idx <= sym_idx + IDX_W'(1);
  end

  // Sticky overflow and saturating drop counter for entries that found no room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + DROP_W'(1);
    end
  end

  // Remembers that anything fired this trace, whether it was kept or dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         any_report <= 1'b0;
    else if (clear)    any_report <= 1'b0;
    else if (push_req) any_report <= 1'b1;
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomized and directed bench for ltl_report_collector with a queue-based reference model.
module tb_ltl_report_collector;
  import ltl_monitor_pkg::*;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       run;
  logic [3:0] report_in;
  logic       out_ready;

  logic        out_valid;
  logic [15:0] out_index;
  logic [3:0]  out_reports;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        any_report;

  logic        out_valid4;
  logic [3:0]  out_index4;
  logic [3:0]  out_reports4;
  logic [3:0]  count4;
  logic        overflow4;
  logic [7:0]  drop_count4;
  logic        any_report4;

  int checkCount;
  int passCount;

  report_entry_t mq[$];
  logic [15:0]   mIdx;
  logic          mOverflow;
  int            mDrop;
  logic          mAny;

  ltl_report_collector dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .run         (run),
    .report_in   (report_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_reports (out_reports),
    .count       (count),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .any_report  (any_report)
  );

  // Narrow-index instance used only to observe symbol-index wraparound.
  ltl_report_collector #(.IDX_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .run         (run),
    .report_in   (report_in),
    .out_valid   (out_valid4),
    .out_ready   (out_ready),
    .out_index   (out_index4),
    .out_reports (out_reports4),
    .count       (count4),
    .overflow    (overflow4),
    .drop_count  (drop_count4),
    .any_report  (any_report4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mq.delete();
    mIdx      = '0;
    mOverflow = 1'b0;
    mDrop     = 0;
    mAny      = 1'b0;
  endtask

  // Reference behaviour: clear wins; otherwise pop the head, then append or drop.
  task automatic modelStep(input logic r, input logic [3:0] rep, input logic rdy, input logic clr);
    int            preSize;
    bit            doPop;
    bit            doPush;
    report_entry_t e;
    report_entry_t gone;
    if (clr) begin
      modelReset();
      return;
    end
    preSize = mq.size();
    doPop   = (preSize > 0) && rdy;
    doPush  = r && (rep != 4'b0);
    e.idx     = mIdx;
    e.reports = rep;
    if (doPop) gone = mq.pop_front();
    if (doPush) begin
      mAny = 1'b1;
      if (preSize < DEPTH || doPop) mq.push_back(e);
      else begin
        mOverflow = 1'b1;
        if (mDrop < 255) mDrop++;
      end
    end
    if (r) mIdx = mIdx + 16'd1;
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    checkOutput("count", 32'(count), 32'(mq.size()));
    if (mq.size() != 0) begin
      checkOutput("out_index", 32'(out_index), 32'(mq[0].idx));
      checkOutput("out_reports", 32'(out_reports), 32'(mq[0].reports));
    end
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    checkOutput("drop_count", 32'(drop_count), 32'(mDrop));
    checkOutput("any_report", 32'(any_report), 32'(mAny));
  endtask

  // One clock of stimulus: drive, compare against the model, clock, advance the model.
  task automatic applyStimulus(input logic r, input logic [3:0] rep, input logic rdy, input logic clr);
    run       = r;
    report_in = rep;
    out_ready = rdy;
    clear     = clr;
    #1;
    checkAll();
    @(posedge clk);
    modelStep(r, rep, rdy, clr);
    @(negedge clk);
  endtask

  task automatic resetDut();
    run       = 1'b0;
    report_in = '0;
    out_ready = 1'b0;
    clear     = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_index", 32'(out_index), 32'd0);
    checkOutput("rst_out_reports", 32'(out_reports), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
    checkOutput("rst_any_report", 32'(any_report), 32'd0);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic       r;
    logic [3:0] rep;
    logic       rdy;
    logic       clr;
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    @(negedge clk);
    resetDut();

    // Single capture at symbol index 3.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i == 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    checkOutput("single_count", 32'(count), 32'd1);
    checkOutput("single_idx", 32'(out_index), 32'd3);
    checkOutput("single_reports", 32'(out_reports), 32'h4);

    // Overfill by two, then drain in order.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("fill_count", 32'(count), 32'd8);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    checkOutput("fill_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_idx", 32'(out_index), 32'(i));
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(out_valid), 32'd0);

    // Push and pop together while full.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
    checkOutput("fullpp_count", 32'(count), 32'd8);
    checkOutput("fullpp_drops", 32'(drop_count), 32'd0);
    checkOutput("fullpp_head", 32'(out_index), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("fullpp_tail_idx", 32'(out_index), 32'd8);
    checkOutput("fullpp_tail_rep", 32'(out_reports), 32'h9);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

    // Reports without run are ignored and do not advance the index.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    checkOutput("norun_count", 32'(count), 32'd0);
    checkOutput("norun_any", 32'(any_report), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("norun_idx", 32'(out_index), 32'd0);

    // Index wraparound on the 4-bit instance.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i == 15 || i == 16) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
    checkOutput("wrap_count", 32'(count4), 32'd2);
    checkOutput("wrap_first", 32'(out_index4), 32'd15);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("wrap_second", 32'(out_index4), 32'd0);

    // Clear beats a simultaneous push and pop.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("pre_clear_count", 32'(count), 32'd5);
    checkOutput("pre_clear_drops", 32'(drop_count), 32'd3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b1);
    checkOutput("clear_count", 32'(count), 32'd0);
    checkOutput("clear_valid", 32'(out_valid), 32'd0);
    checkOutput("clear_overflow", 32'(overflow), 32'd0);
    checkOutput("clear_drops", 32'(drop_count), 32'd0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    checkOutput("clear_next_idx", 32'(out_index), 32'd0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_index", 32'(out_index), 32'd0);
    checkOutput("midrst_any", 32'(any_report), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    // Randomized traffic with varying consumer pressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 3) != 0);
      rep = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'b0000;
      rdy = ($urandom_range(0, 99) < ((i % 200) < 100 ? 25 : 75));
      clr = ($urandom_range(0, 79) == 0);
      applyStimulus(r, rep, rdy, clr);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
